// File: rtl/piece_drop_ctrl_pkg.sv
// Shared game definitions for the piece/board pipeline: board geometry,
// controller state codes (also the clear_redraw command) and piece/move codes.
package tetris_pkg;

    localparam int BOARD_W = 8;
    localparam int BOARD_H = 4;

    typedef enum logic [2:0] {
        SPAWN = 3'd0,
        CLEAR = 3'd1,
        FALL  = 3'd2,
        LOCK  = 3'd3,
        OVER  = 3'd4
    } game_state_e;

    localparam logic [1:0] PIECE_1X1 = 2'd0;
    localparam logic [1:0] PIECE_H2  = 2'd1;
    localparam logic [1:0] PIECE_V2  = 2'd2;
    localparam logic [1:0] PIECE_SQ  = 2'd3;

    localparam logic [1:0] MOVE_NONE  = 2'd0;
    localparam logic [1:0] MOVE_LEFT  = 2'd1;
    localparam logic [1:0] MOVE_RIGHT = 2'd2;
    localparam logic [1:0] MOVE_DROP  = 2'd3;

    // Cell pattern of a piece anchored at row 0, column 0.
    function automatic logic [31:0] piece_shape(input logic [1:0] piece);
        case (piece)
            PIECE_1X1: piece_shape = 32'h0000_0001;
            PIECE_H2:  piece_shape = 32'h0000_0003;
            PIECE_V2:  piece_shape = 32'h0000_0101;
            default:   piece_shape = 32'h0000_0303;
        endcase
    endfunction

endpackage

// File: rtl/piece_drop_ctrl_if.sv
// Game-loop bundle between the piece controller (slave) and its environment:
// rng, player input and clear_redraw (master).
interface piece_drop_if
    import tetris_pkg::*;
;
    logic [1:0]  next_piece;
    logic [1:0]  move;
    logic [31:0] board_in;
    logic [31:0] board_out;
    logic [4:0]  location;
    logic [1:0]  curr_piece;
    game_state_e state;
    logic [31:0] piece_mask;
    logic        game_over;

    modport slave (
        input  next_piece, move, board_in,
        output board_out, location, curr_piece, state, piece_mask, game_over
    );

    modport master (
        output next_piece, move, board_in,
        input  board_out, location, curr_piece, state, piece_mask, game_over
    );
endinterface

// File: rtl/piece_drop_ctrl_mask_gen.sv
// Maps a piece code and anchor {row, col} to the board cells it covers,
// plus its width and height in cells.
module piece_mask_gen
    import tetris_pkg::*;
(
    input  logic [1:0]  piece,
    input  logic [4:0]  loc,
    output logic [31:0] mask,
    output logic [1:0]  w,
    output logic [1:0]  h
);

    // The anchor bits are exactly the bit index row*8+col, so a plain shift places the piece.
    always_comb begin
        mask = piece_shape(piece) << loc;
        w    = (piece == PIECE_H2 || piece == PIECE_SQ) ? 2'd2 : 2'd1;
        h    = (piece == PIECE_V2 || piece == PIECE_SQ) ? 2'd2 : 2'd1;
    end

endmodule

// File: rtl/piece_drop_ctrl.sv
// Game-flow controller: spawns pieces, moves them under input and gravity,
// locks them into the board and sequences the clear_redraw command.
module piece_drop_ctrl
    import tetris_pkg::*;
#(
    parameter int GRAVITY_DIV = 4,
    parameter int SPAWN_COL   = 3
) (
    input  logic         clka,
    input  logic         restart,
    piece_drop_if.slave  bus
);

    localparam int              CNT_W     = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GRAVITY_DIV - 1);
    localparam logic [4:0]      SPAWN_LOC = {2'd0, 3'(SPAWN_COL)};

    game_state_e      state, state_nxt;
    logic [4:0]       location, loc_nxt;
    logic [1:0]       curr_piece, piece_nxt;
    logic [31:0]      board_out, board_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             game_over, over_nxt;

    logic [31:0] cur_mask, h_mask, d_mask;
    logic [1:0]  cur_w, cur_h, h_w, h_h, d_w, d_h;
    logic [1:0]  h_piece;
    logic [4:0]  h_loc, post_loc, d_loc;
    logic        h_guard, h_legal, d_guard, d_legal, v_trig;

    piece_mask_gen u_cur  (.piece(curr_piece), .loc(location), .mask(cur_mask), .w(cur_w), .h(cur_h));
    piece_mask_gen u_horz (.piece(h_piece),    .loc(h_loc),    .mask(h_mask),   .w(h_w),   .h(h_h));
    piece_mask_gen u_down (.piece(curr_piece), .loc(d_loc),    .mask(d_mask),   .w(d_w),   .h(d_h));

    // The horizontal candidate doubles as the spawn check while in SPAWN.
    // Guards reject moves whose anchor arithmetic would wrap into another row.
    assign h_piece = (state == SPAWN) ? bus.next_piece : curr_piece;

    always_comb begin
        h_loc   = location;
        h_guard = 1'b0;
        if (state == SPAWN) begin
            h_loc   = SPAWN_LOC;
            h_guard = 1'b1;
        end else begin
            case (bus.move)
                MOVE_LEFT: begin
                    h_loc   = location - 5'd1;
                    h_guard = (location[2:0] != 3'd0);
                end
                MOVE_RIGHT: begin
                    h_loc   = location + 5'd1;
                    h_guard = (({1'b0, location[2:0]} + {2'b0, cur_w}) < 4'(BOARD_W));
                end
                default: ;
            endcase
        end
    end

    assign h_legal  = h_guard
                   && (({1'b0, h_loc[2:0]} + {2'b0, h_w}) <= 4'(BOARD_W))
                   && (({1'b0, h_loc[4:3]} + {1'b0, h_h}) <= 3'(BOARD_H))
                   && ((h_mask & bus.board_in) == 32'd0);
    assign post_loc = h_legal ? h_loc : location;

    assign d_loc    = post_loc + 5'(BOARD_W);
    assign d_guard  = (({1'b0, post_loc[4:3]} + {1'b0, cur_h}) < 3'(BOARD_H));
    assign d_legal  = d_guard
                   && (({1'b0, d_loc[2:0]} + {2'b0, d_w}) <= 4'(BOARD_W))
                   && (({1'b0, d_loc[4:3]} + {1'b0, d_h}) <= 3'(BOARD_H))
                   && ((d_mask & bus.board_in) == 32'd0);
    assign v_trig   = (bus.move == MOVE_DROP) || (cnt == CNT_MAX);

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state      <= SPAWN;
            location   <= 5'd0;
            curr_piece <= 2'd0;
            board_out  <= 32'd0;
            cnt        <= '0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nxt;
            location   <= loc_nxt;
            curr_piece <= piece_nxt;
            board_out  <= board_nxt;
            cnt        <= cnt_nxt;
            game_over  <= over_nxt;
        end
    end

    // Only LOCK alters the board; every other state forwards board_in unchanged.
    always_comb begin
        state_nxt = state;
        loc_nxt   = location;
        piece_nxt = curr_piece;
        board_nxt = bus.board_in;
        cnt_nxt   = cnt;
        over_nxt  = game_over;
        case (state)
            SPAWN: begin
                piece_nxt = bus.next_piece;
                loc_nxt   = SPAWN_LOC;
                cnt_nxt   = '0;
                if (h_legal) begin
                    state_nxt = FALL;
                end else begin
                    state_nxt = OVER;
                    over_nxt  = 1'b1;
                end
            end
            FALL: begin
                loc_nxt = post_loc;
                if (v_trig) begin
                    if (d_legal) begin
                        loc_nxt = d_loc;
                        cnt_nxt = '0;
                    end else begin
                        state_nxt = LOCK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOCK: begin
                board_nxt = bus.board_in | cur_mask;
                state_nxt = CLEAR;
            end
            CLEAR:   state_nxt = SPAWN;
            OVER:    state_nxt = OVER;
            default: state_nxt = SPAWN;
        endcase
    end

    assign bus.board_out  = board_out;
    assign bus.location   = location;
    assign bus.curr_piece = curr_piece;
    assign bus.state      = state;
    assign bus.piece_mask = cur_mask;
    assign bus.game_over  = game_over;

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Directed bench for piece_drop_ctrl: one DUT at the default gravity rate and
// one with very slow gravity so horizontal moves can be observed in isolation.
module tb_piece_drop_ctrl;
    import tetris_pkg::*;

    logic clka    = 1'b0;
    logic restart = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    piece_drop_if bf ();
    piece_drop_if bs ();

    piece_drop_ctrl #(.GRAVITY_DIV(4), .SPAWN_COL(3)) dut_fast (
        .clka(clka), .restart(restart), .bus(bf)
    );
    piece_drop_ctrl #(.GRAVITY_DIV(64), .SPAWN_COL(3)) dut_slow (
        .clka(clka), .restart(restart), .bus(bs)
    );

    always #5 clka = ~clka;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clka);
        restart = 1'b1;
        @(negedge clka);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (bf.state !== SPAWN) $display("[TB] FAIL reset_state: got %0d expected 0", bf.state); else pass_cnt++;
        total_cnt++; if (bf.location !== 5'd0) $display("[TB] FAIL reset_location: got %0d expected 0", bf.location); else pass_cnt++;
        total_cnt++; if (bf.curr_piece !== 2'd0) $display("[TB] FAIL reset_piece: got %0d expected 0", bf.curr_piece); else pass_cnt++;
        total_cnt++; if (bf.board_out !== 32'd0) $display("[TB] FAIL reset_board: got 0x%08h expected 0x00000000", bf.board_out); else pass_cnt++;
        total_cnt++; if (bf.game_over !== 1'b0) $display("[TB] FAIL reset_game_over: got %0b expected 0", bf.game_over); else pass_cnt++;
        total_cnt++; if (bf.piece_mask !== 32'h1) $display("[TB] FAIL reset_mask: got 0x%08h expected 0x00000001", bf.piece_mask); else pass_cnt++;
        @(negedge clka);
        restart = 1'b0;
    endtask

    task automatic test_drop_lock();
        bf.next_piece = PIECE_SQ; bf.board_in = 32'd0; bf.move = MOVE_DROP;
        pulse_reset();
        tick();
        total_cnt++; if (bf.state !== FALL) $display("[TB] FAIL spawn_state: got %0d expected 2", bf.state); else pass_cnt++;
        total_cnt++; if (bf.location !== 5'd3) $display("[TB] FAIL spawn_location: got %0d expected 3", bf.location); else pass_cnt++;
        total_cnt++; if (bf.curr_piece !== 2'd3) $display("[TB] FAIL spawn_piece: got %0d expected 3", bf.curr_piece); else pass_cnt++;
        total_cnt++; if (bf.piece_mask !== 32'h1818) $display("[TB] FAIL spawn_mask: got 0x%08h expected 0x00001818", bf.piece_mask); else pass_cnt++;
        tick();
        total_cnt++; if (bf.location !== 5'd11) $display("[TB] FAIL drop1_location: got %0d expected 11", bf.location); else pass_cnt++;
        tick();
        total_cnt++; if (bf.location !== 5'd19) $display("[TB] FAIL drop2_location: got %0d expected 19", bf.location); else pass_cnt++;
        tick();
        total_cnt++; if (bf.state !== LOCK) $display("[TB] FAIL land_state: got %0d expected 3", bf.state); else pass_cnt++;
        total_cnt++; if (bf.location !== 5'd19) $display("[TB] FAIL land_location: got %0d expected 19", bf.location); else pass_cnt++;
        tick();
        total_cnt++; if (bf.board_out !== 32'h1818_0000) $display("[TB] FAIL lock_board: got 0x%08h expected 0x18180000", bf.board_out); else pass_cnt++;
        total_cnt++; if (bf.state !== CLEAR) $display("[TB] FAIL lock_next_state: got %0d expected 1", bf.state); else pass_cnt++;
        tick();
        total_cnt++; if (bf.state !== SPAWN) $display("[TB] FAIL clear_next_state: got %0d expected 0", bf.state); else pass_cnt++;
        total_cnt++; if (bf.board_out !== 32'd0) $display("[TB] FAIL clear_board: got 0x%08h expected 0x00000000", bf.board_out); else pass_cnt++;
    endtask

    task automatic test_gravity();
        bf.next_piece = PIECE_1X1; bf.board_in = 32'd0; bf.move = MOVE_NONE;
        pulse_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (bf.location !== 5'd3) $display("[TB] FAIL gravity_hold%0d: got %0d expected 3", i, bf.location); else pass_cnt++;
            tick();
        end
        total_cnt++; if (bf.location !== 5'd11) $display("[TB] FAIL gravity_step: got %0d expected 11", bf.location); else pass_cnt++;
        for (int i = 0; i < 3; i++) tick();
        total_cnt++; if (bf.location !== 5'd11) $display("[TB] FAIL gravity_rehold: got %0d expected 11", bf.location); else pass_cnt++;
        bf.move = MOVE_DROP;
        tick();
        total_cnt++; if (bf.location !== 5'd19) $display("[TB] FAIL drop_plus_gravity: got %0d expected 19", bf.location); else pass_cnt++;
        tick();
        total_cnt++; if (bf.location !== 5'd27) $display("[TB] FAIL bottom_row_location: got %0d expected 27", bf.location); else pass_cnt++;
        tick();
        total_cnt++; if (bf.state !== LOCK) $display("[TB] FAIL bottom_row_lock: got %0d expected 3", bf.state); else pass_cnt++;
        tick();
        total_cnt++; if (bf.board_out !== 32'h0800_0000) $display("[TB] FAIL bottom_row_board: got 0x%08h expected 0x08000000", bf.board_out); else pass_cnt++;
        bf.move = MOVE_NONE;
    endtask

    task automatic test_move_left();
        logic [4:0] exp_loc [5] = '{5'd2, 5'd1, 5'd0, 5'd0, 5'd0};
        bs.next_piece = PIECE_1X1; bs.board_in = 32'd0; bs.move = MOVE_NONE;
        pulse_reset();
        tick();
        bs.move = MOVE_LEFT;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (bs.location !== exp_loc[i]) $display("[TB] FAIL left%0d: got %0d expected %0d", i, bs.location, exp_loc[i]); else pass_cnt++;
        end
        total_cnt++; if (bs.state !== FALL) $display("[TB] FAIL left_wall_state: got %0d expected 2", bs.state); else pass_cnt++;
        bs.move = MOVE_NONE;
    endtask

    task automatic test_move_right();
        logic [4:0] exp_loc [5] = '{5'd4, 5'd5, 5'd6, 5'd6, 5'd6};
        bs.next_piece = PIECE_H2; bs.board_in = 32'd0; bs.move = MOVE_NONE;
        pulse_reset();
        tick();
        total_cnt++; if (bs.piece_mask !== 32'h18) $display("[TB] FAIL h2_spawn_mask: got 0x%08h expected 0x00000018", bs.piece_mask); else pass_cnt++;
        bs.move = MOVE_RIGHT;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (bs.location !== exp_loc[i]) $display("[TB] FAIL right%0d: got %0d expected %0d", i, bs.location, exp_loc[i]); else pass_cnt++;
        end
        total_cnt++; if (bs.piece_mask !== 32'hC0) $display("[TB] FAIL right_wall_mask: got 0x%08h expected 0x000000c0", bs.piece_mask); else pass_cnt++;
        bs.move = MOVE_NONE;
    endtask

    task automatic test_stack_block();
        bs.next_piece = PIECE_1X1; bs.board_in = 32'h0000_1004; bs.move = MOVE_NONE;
        pulse_reset();
        tick();
        total_cnt++; if (bs.state !== FALL) $display("[TB] FAIL stack_spawn_state: got %0d expected 2", bs.state); else pass_cnt++;
        bs.move = MOVE_LEFT;
        tick();
        total_cnt++; if (bs.location !== 5'd3) $display("[TB] FAIL stack_left_blocked: got %0d expected 3", bs.location); else pass_cnt++;
        bs.move = MOVE_RIGHT;
        tick();
        total_cnt++; if (bs.location !== 5'd4) $display("[TB] FAIL stack_right: got %0d expected 4", bs.location); else pass_cnt++;
        bs.move = MOVE_DROP;
        tick();
        total_cnt++; if (bs.state !== LOCK) $display("[TB] FAIL stack_land_state: got %0d expected 3", bs.state); else pass_cnt++;
        total_cnt++; if (bs.location !== 5'd4) $display("[TB] FAIL stack_land_location: got %0d expected 4", bs.location); else pass_cnt++;
        tick();
        total_cnt++; if (bs.board_out !== 32'h0000_1014) $display("[TB] FAIL stack_merge: got 0x%08h expected 0x00001014", bs.board_out); else pass_cnt++;
        tick();
        total_cnt++; if (bs.board_out !== 32'h0000_1004) $display("[TB] FAIL stack_passthru: got 0x%08h expected 0x00001004", bs.board_out); else pass_cnt++;
        bs.move = MOVE_NONE; bs.board_in = 32'd0;
    endtask

    task automatic test_game_over();
        bf.next_piece = PIECE_1X1; bf.board_in = 32'h0000_0018; bf.move = MOVE_NONE;
        pulse_reset();
        tick();
        total_cnt++; if (bf.state !== OVER) $display("[TB] FAIL over_state: got %0d expected 4", bf.state); else pass_cnt++;
        total_cnt++; if (bf.game_over !== 1'b1) $display("[TB] FAIL over_flag: got %0b expected 1", bf.game_over); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            bf.move = 2'(i % 4);
            bf.next_piece = 2'((i + 1) % 4);
            tick();
            total_cnt++;
            if (bf.state !== OVER || bf.game_over !== 1'b1 || bf.location !== 5'd3)
                $display("[TB] FAIL over_hold%0d: got state %0d flag %0b loc %0d expected 4 1 3", i, bf.state, bf.game_over, bf.location);
            else pass_cnt++;
        end
        @(negedge clka);
        restart = 1'b1;
        #1;
        total_cnt++; if (bf.state !== SPAWN) $display("[TB] FAIL over_restart_state: got %0d expected 0", bf.state); else pass_cnt++;
        total_cnt++; if (bf.game_over !== 1'b0) $display("[TB] FAIL over_restart_flag: got %0b expected 0", bf.game_over); else pass_cnt++;
        @(negedge clka);
        restart = 1'b0;
        bf.board_in = 32'd0; bf.move = MOVE_NONE;
    endtask

    task automatic test_restart_mid();
        bf.next_piece = PIECE_1X1; bf.board_in = 32'd0; bf.move = MOVE_DROP;
        pulse_reset();
        tick();
        tick();
        total_cnt++; if (bf.location !== 5'd11) $display("[TB] FAIL midfall_location: got %0d expected 11", bf.location); else pass_cnt++;
        #2;
        restart = 1'b1;
        #1;
        total_cnt++;
        if (bf.state !== SPAWN || bf.location !== 5'd0 || bf.curr_piece !== 2'd0 || bf.board_out !== 32'd0 || bf.game_over !== 1'b0 || bf.piece_mask !== 32'h1)
            $display("[TB] FAIL midfall_async_reset: got state %0d loc %0d piece %0d board 0x%08h flag %0b mask 0x%08h expected 0 0 0 0 0 1",
                     bf.state, bf.location, bf.curr_piece, bf.board_out, bf.game_over, bf.piece_mask);
        else pass_cnt++;
        @(negedge clka);
        restart = 1'b0;

        bf.next_piece = PIECE_SQ;
        pulse_reset();
        for (int i = 0; i < 4; i++) tick();
        total_cnt++; if (bf.state !== LOCK) $display("[TB] FAIL midlock_state: got %0d expected 3", bf.state); else pass_cnt++;
        #2;
        restart = 1'b1;
        #1;
        total_cnt++; if (bf.state !== SPAWN) $display("[TB] FAIL midlock_async_state: got %0d expected 0", bf.state); else pass_cnt++;
        tick();
        total_cnt++; if (bf.board_out !== 32'd0) $display("[TB] FAIL midlock_no_merge: got 0x%08h expected 0x00000000", bf.board_out); else pass_cnt++;
        @(negedge clka);
        restart = 1'b0;
        tick();
        total_cnt++; if (bf.state !== FALL || bf.board_out !== 32'd0) $display("[TB] FAIL midlock_respawn: got state %0d board 0x%08h expected 2 0x00000000", bf.state, bf.board_out); else pass_cnt++;
        bf.move = MOVE_NONE;
    endtask

    initial begin
        bf.next_piece = 2'd0; bf.move = MOVE_NONE; bf.board_in = 32'd0;
        bs.next_piece = 2'd0; bs.move = MOVE_NONE; bs.board_in = 32'd0;
        test_reset();
        test_drop_lock();
        test_gravity();
        test_move_left();
        test_move_right();
        test_stack_block();
        test_game_over();
        test_restart_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL timeout: simulation exceeded 50000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule
